// File: rtl/rcu_arb_pkg.sv
// Shared helpers for the RCU age-ordered arbiters: vector rotation, find-first
// and parameter sanity checks. Vectors are carried at a fixed maximum width.
package rcu_arb_pkg;

    localparam int unsigned MAX_SEL = 64;
    localparam int unsigned MAX_SEL_W = 6;

    typedef logic [MAX_SEL-1:0] sel_vec_t;

    // True when sel is a power of two >= 4 and pw == $clog2(sel).
    function automatic bit width_ok(input int unsigned sel, input int unsigned pw);
        return (sel >= 4) && (sel <= MAX_SEL) && ((sel & (sel - 1)) == 0)
               && (pw == $clog2(sel));
    endfunction

    // Rotate the low w bits of v right by amt, so bit amt lands at position 0.
    function automatic sel_vec_t rotr(input sel_vec_t v, input int unsigned amt,
                                      input int unsigned w);
        sel_vec_t r;
        r = '0;
        for (int unsigned i = 0; i < MAX_SEL; i++) begin
            if (i < w) begin
                r[i[MAX_SEL_W-1:0]] = v[MAX_SEL_W'((i + amt) % w)];
            end
        end
        return r;
    endfunction

    // Position of the lowest set bit; 0 when v is empty.
    function automatic int unsigned find_first(input sel_vec_t v);
        int unsigned f;
        f = 0;
        for (int i = MAX_SEL - 1; i >= 0; i--) begin
            if (v[i[MAX_SEL_W-1:0]]) begin
                f = i;
            end
        end
        return f;
    endfunction

endpackage

// File: rtl/oldest_n_select.sv
// Combinational oldest-first N-select: rotate requests so head is bit 0, peel
// off the first N set bits in order, then translate back to absolute indices.
module oldest_n_select
    import rcu_arb_pkg::*;
#(
    parameter int SEL_WIDTH      = 16,
    parameter int PRIORITY_WIDTH = 4,
    parameter int GRANT_NUM      = 2
) (
    input  logic [SEL_WIDTH-1:0]                eff_req_i,
    input  logic [PRIORITY_WIDTH-1:0]           head_i,
    output logic [GRANT_NUM-1:0]                valid_o,
    output logic [GRANT_NUM*PRIORITY_WIDTH-1:0] index_o
);

    sel_vec_t    rem [GRANT_NUM];
    int unsigned ff  [GRANT_NUM];

    assign rem[0] = rotr(sel_vec_t'(eff_req_i), 32'(head_i), SEL_WIDTH);

    genvar gi;
    generate
        for (gi = 0; gi < GRANT_NUM; gi++) begin : g_slot
            assign ff[gi]      = find_first(rem[gi]);
            assign valid_o[gi] = |rem[gi];
            // Index arithmetic wraps naturally because SEL_WIDTH is a power of two.
            assign index_o[gi*PRIORITY_WIDTH +: PRIORITY_WIDTH] =
                valid_o[gi] ? PRIORITY_WIDTH'(ff[gi]) + head_i : '0;
            if (gi < GRANT_NUM - 1) begin : g_next
                assign rem[gi+1] = rem[gi] & ~(sel_vec_t'(1) << ff[gi]);
            end
        end
    endgenerate

endmodule

// File: rtl/oldest_n_issue_arbiter.sv
// Registered oldest-first arbiter granting up to GRANT_NUM entries per cycle.
// Optional perf counters (stall_cnt_o, grant_cnt_o) under OLDEST_ARB_PERF_CNT_EN.
module oldest_n_issue_arbiter
    import rcu_arb_pkg::*;
#(
    parameter int SEL_WIDTH      = 16,
    parameter int PRIORITY_WIDTH = 4,
    parameter int GRANT_NUM      = 2
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [SEL_WIDTH-1:0]                req_i,
    input  logic [PRIORITY_WIDTH-1:0]           head_adv_i,
    input  logic                                flush_i,
    input  logic [PRIORITY_WIDTH-1:0]           flush_head_i,
    input  logic                                grant_ready_i,
    output logic [GRANT_NUM-1:0]                grant_valid_o,
    output logic [GRANT_NUM*PRIORITY_WIDTH-1:0] grant_index_o,
    output logic [PRIORITY_WIDTH-1:0]           head_ptr_o
`ifdef OLDEST_ARB_PERF_CNT_EN
    ,
    output logic [31:0]                         stall_cnt_o,
    output logic [31:0]                         grant_cnt_o
`endif
);

    localparam bit CFG_OK = width_ok(SEL_WIDTH, PRIORITY_WIDTH)
                            && (GRANT_NUM >= 1) && (GRANT_NUM <= 4);

    generate
        if (!CFG_OK) begin : g_cfg_check
            $error("oldest_n_issue_arbiter: illegal SEL_WIDTH/PRIORITY_WIDTH/GRANT_NUM");
        end
    endgenerate

    logic [PRIORITY_WIDTH-1:0]           head_q, head_d;
    logic [GRANT_NUM-1:0]                valid_q, valid_d;
    logic [GRANT_NUM*PRIORITY_WIDTH-1:0] index_q, index_d;
    logic [SEL_WIDTH-1:0]                held;
    logic [SEL_WIDTH-1:0]                eff_req;
    logic [GRANT_NUM-1:0]                sel_valid;
    logic [GRANT_NUM*PRIORITY_WIDTH-1:0] sel_index;
    logic                                load;

    // Entries already sitting in the output register must not be granted twice.
    always_comb begin
        held = '0;
        for (int k = 0; k < GRANT_NUM; k++) begin
            if (valid_q[k]) begin
                held[index_q[k*PRIORITY_WIDTH +: PRIORITY_WIDTH]] = 1'b1;
            end
        end
    end

    assign eff_req = req_i & ~held;

    oldest_n_select #(
        .SEL_WIDTH      (SEL_WIDTH),
        .PRIORITY_WIDTH (PRIORITY_WIDTH),
        .GRANT_NUM      (GRANT_NUM)
    ) u_select (
        .eff_req_i (eff_req),
        .head_i    (head_q),
        .valid_o   (sel_valid),
        .index_o   (sel_index)
    );

    assign load = (~(|valid_q) | grant_ready_i) & ~flush_i;

    always_comb begin
        head_d  = head_q + head_adv_i;
        valid_d = valid_q;
        index_d = index_q;
        if (flush_i) begin
            head_d  = flush_head_i;
            valid_d = '0;
            index_d = '0;
        end else if (load) begin
            valid_d = sel_valid;
            index_d = sel_index;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            valid_q <= '0;
            index_q <= '0;
        end else begin
            head_q  <= head_d;
            valid_q <= valid_d;
            index_q <= index_d;
        end
    end

    assign grant_valid_o = valid_q;
    assign grant_index_o = index_q;
    assign head_ptr_o    = head_q;

`ifdef OLDEST_ARB_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] grant_cnt_q, grant_cnt_d;
    logic [32:0] grant_sum;

    assign grant_sum = {1'b0, grant_cnt_q} + 33'($countones(valid_q));

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        grant_cnt_d = grant_cnt_q;
        if ((|valid_q) && !grant_ready_i && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (grant_ready_i) begin
            grant_cnt_d = grant_sum[32] ? 32'hFFFF_FFFF : grant_sum[31:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            grant_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            grant_cnt_q <= grant_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign grant_cnt_o = grant_cnt_q;
`endif

endmodule
